restoring_divider_16: RTL and testbench

Sequential unsigned restoring divider, the inverse of the team's 16-bit Dadda multiplier. It computes `quotient = dividend / divisor` and `remainder = dividend % divisor` over WIDTH iterations, one quotient bit per clock. The trial subtraction runs on a WIDTH+1-bit ripple-carry chain of `fullAdder` instances. It sits beside the multiplier in the arithmetic datapath and is driven through a start/ready/done handshake.

---
 rtl/restoring_divider_16.sv | 150 +++++++++++++++
 tb/tb_restoring_divider_16.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_16.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the trial
// subtraction done on a WIDTH+1-bit ripple-carry chain of fullAdder cells.
module restoring_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH+1:0] w_c;
  logic [WIDTH-1:0] w_q_next;
  logic             w_no_borrow;
  logic             w_accept;
  logic             w_dz;
  logic             w_last;
  logic             w_unused_guard;

  // Guard bit of R is always 0 after a restore; it only widens the trial subtraction.
  assign w_unused_guard = r_r[WIDTH];

  assign w_s = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_b = ~{1'b0, r_d};
  assign w_c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    fullAdder u_fa (
      .a   (w_s[i]),
      .b   (w_b[i]),
      .cin (w_c[i]),
      .sum (w_t[i]),
      .cout(w_c[i+1])
    );
  end

  assign w_no_borrow = w_c[WIDTH+1];
  assign w_r_next    = w_no_borrow ? w_t : w_s;
  assign w_q_next    = {r_q[WIDTH-2:0], w_no_borrow};

  // Handshake: start is taken only on an edge where ready=1; done pulses for exactly
  // one cycle when results land, and ready is already high again in that cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_dz         = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            w_dz = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign ready     = (r_state == S_IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_r   <= '0;
        r_q   <= dividend;
        r_d   <= divisor;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_r   <= w_r_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_dz) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
      if (w_last) begin
        quotient    <= w_q_next;
        remainder   <= w_r_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

endmodule

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_restoring_divider_16.sv
// Bench for restoring_divider_16: directed vector table, busy/reset sequences and a
// randomized sweep checked against plain / and % arithmetic.
module tb_restoring_divider_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  restoring_divider_16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Driver: called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output bit rdy_ok);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    lat      = 0;
    rdy_ok   = 1'b1;
    do begin
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      lat++;
      if (!done && ready) rdy_ok = 1'b0;
    end while (!done && lat < 40);
  endtask

  initial begin
    vec_t vecs[7];
    int   lat;
    bit   rdy_ok;
    int   n_done;
    int   done_at;
    logic [31:0] e;

    vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0};
    vecs[1] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,    1'b0};
    vecs[2] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    1'b0};
    vecs[3] = '{16'd3,     16'd10,    16'd0,     16'd3,    1'b0};
    vecs[4] = '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0};
    vecs[5] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1};
    vecs[6] = '{16'd9,     16'd4,     16'd2,     16'd1,    1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quot", 32'(quotient), 32'd0);
    chk("reset_rem", 32'(remainder), 32'd0);
    chk("reset_dz", 32'(div_by_zero), 32'd0);

    // Directed vectors, issued back-to-back from each done cycle.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, rdy_ok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].dz ? 32'd1 : 32'd17);
      chk($sformatf("vec%0d_quot", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("vec%0d_rem", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_ready_busy", i), 32'(rdy_ok), 32'd1);
      chk($sformatf("vec%0d_ready_at_done", i), 32'(ready), 32'd1);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Busy: a second start at E5 must be ignored.
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    n_done = 0; done_at = 0;
    for (int c = 6; c <= 35; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        n_done++;
        if (done_at == 0) begin
          done_at = c;
          chk("busy_quot", 32'(quotient), 32'd333);
          chk("busy_rem", 32'(remainder), 32'd1);
        end
      end
    end
    chk("busy_done_count", 32'(n_done), 32'd1);
    chk("busy_done_cycle", 32'(done_at), 32'd17);
    chk("busy_hold_quot", 32'(quotient), 32'd333);
    chk("busy_hold_rem", 32'(remainder), 32'd1);
    chk("busy_hold_ready", 32'(ready), 32'd1);

    // Reset at E8 of a 500/9 operation.
    start = 1'b1; dividend = 16'd500; divisor = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quot", 32'(quotient), 32'd0);
    chk("abort_rem", 32'(remainder), 32'd0);
    chk("abort_dz", 32'(div_by_zero), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    n_done = 32'(done);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    run_op(16'd500, 16'd9, lat, rdy_ok);
    chk("after_abort_latency", 32'(lat), 32'd17);
    chk("after_abort_quot", 32'(quotient), 32'd55);
    chk("after_abort_rem", 32'(remainder), 32'd5);

    // Random sweep with scoreboard.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      exp_q.push_back({a / b, a % b});
      run_op(a, b, lat, rdy_ok);
      e = exp_q.pop_front();
      chk("rand_latency", 32'(lat), 32'd17);
      chk("rand_quot", 32'(quotient), 32'(e[31:16]));
      chk("rand_rem", 32'(remainder), 32'(e[15:0]));
      chk("rand_dz", 32'(div_by_zero), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
